video_osd_overlay: RTL and testbench
====================================

// Module: video_osd_overlay
// PURPOSE
//  Status overlay between video_timing_data and the VGA pins, in the video pixel-clock domain.
//  Draws a 12-cell status bar on the active picture: 4 cells for SD state_code, 8 cells for the SD page number.
//  Adds a blinking red frame border while a photo save is in progress.
//  All inputs pass through a fixed 2-cycle pipeline, so syncs stay aligned with pixel data.
// PARAMETERS
//  H_ACTIVE      1024  active pixels per line
//  V_ACTIVE      768   active lines per frame
//  BOX_X         16    status-bar left x (pixels)
//  BOX_Y         16    status-bar top y (lines)
//  CELL_W        16    cell width, pixels
//  CELL_H        16    cell height, lines
//  BORDER_W      4     save-border thickness, pixels/lines
//  BLINK_FRAMES  16    frames per border blink phase (>=1)
//  SYNC_POL      0     active level of hs/vs (0 = active-low)
// PORTS
//  clk         in   1   pixel clock (video_clk)
//  rst         in   1   synchronous reset, active-high
//  osd_en      in   1   1 = overlay drawn; 0 = pixel passthrough (latency unchanged)
//  saving      in   1   photo save in progress
//  state_code  in   4   SD controller state code
//  page_num    in   8   current SD page index
//  hs_i        in   1   horizontal sync from the timing generator
//  vs_i        in   1   vertical sync from the timing generator
//  de_i        in   1   active-video enable
//  data_i      in   16  RGB565 pixel
//  hs_o        out  1   hs_i delayed 2 cycles
//  vs_o        out  1   vs_i delayed 2 cycles
//  de_o        out  1   de_i delayed 2 cycles
//  data_o      out  16  RGB565 result, 2 cycles after data_i
// BEHAVIOUR
//  Reset: hs_o/vs_o = ~SYNC_POL; de_o = 0; data_o = 0; x = y = 0; blink phase = ON; blink counter = 0; latched fields = 0.
//  Stage 1: register the inputs, x, y and region flags. Stage 2: select colour, register the outputs.
//  x counter: +1 on each de_i cycle; clears on the cycle after de_i falls; saturates at H_ACTIVE-1 if de_i runs long.
//  y counter: +1 on each de_i falling edge; saturates at V_ACTIVE-1; clears on the vs_i edge into the active level.
//  Frame start is the vs_i edge into the active level. On that cycle:
//   - state_code, page_num and saving are latched, so fields never change mid-frame.
//   - The blink counter advances. At BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
//   - Clearing saving also forces the phase to ON and the counter to 0.
//  Status-bar region: BOX_X <= x < BOX_X+12*CELL_W and BOX_Y <= y < BOX_Y+CELL_H.
//   Cell index c = (x-BOX_X)/CELL_W. Division is by a compare chain; no divider.
//   Cells 0..3 show state_code[3..0]; cells 4..11 show page_num[7..0].
//   Bit 1 = 16'hFFFF, bit 0 = 16'h2104.
//   The last column and last row of each cell draw 16'h0000 (separator).
//  Border region: x<BORDER_W, x>=H_ACTIVE-BORDER_W, y<BORDER_W or y>=V_ACTIVE-BORDER_W.
//   Draws 16'hF800 when latched saving=1 and the phase is ON.
//  Priority: status bar > border > data_i. The overlay applies only while de=1; data passes unchanged while de=0.
//  osd_en is sampled every cycle in stage 1. A toggle mid-line takes effect at the pixel sampled that cycle.
//  Boxes that extend past H_ACTIVE/V_ACTIVE are clipped. Reset mid-frame: counters restart and output is valid from the next frame start.
// CONFIGURATION
//  OSD_ALPHA_EN defined: status-bar pixels are a 50% blend, ((data>>1)&16'h7BEF)+((osd>>1)&16'h7BEF).
//   The border stays opaque.
//  OSD_ALPHA_EN undefined: status-bar pixels replace video opaquely.
//  Latency is 2 cycles in both builds.
// STRUCTURE
//  Package video_osd_pkg holds:
//   - colours: OSD_WHITE, OSD_DARK, OSD_BLACK, OSD_RED
//   - OSD_CELLS = 12, OSD_STATE_CELLS = 4, RGB565_HALF_MASK = 16'h7BEF
//  Sub-module osd_cell_decoder: combinational x/y -> {in_box, cell_idx[3:0], is_sep}.
//  Counters, latches, blink logic and the pipeline stay in the top module.
// TESTING
//  1. Defaults, osd_en=1, state_code=4'b1010, page_num=8'h05.
//     -> Line y=16, x=16..207: cells 0..3 = FFFF,2104,FFFF,2104; cells 4..11 = 2104x5, FFFF, 2104, FFFF.
//     -> Column x=31 = 0000; row y=31 = 0000.
//  2. osd_en=0 with a ramp on data_i. -> data_o == data_i delayed exactly 2 cycles; hs/vs/de delayed 2.
//  3. saving=1 from reset, BLINK_FRAMES=2.
//     -> Frames 0-1 border F800; frames 2-3 video; frames 4-5 F800.
//     -> Drop saving in frame 3: no border in frame 4.
//  4. Change page_num 05->06 mid-frame. -> Current frame still shows 05; next frame shows 06.
//  5. de_i held 1100 cycles. -> x saturates at 1023, no wrap into the box; y advances by exactly 1.
//  6. OSD_ALPHA_EN build, data_i=16'h0000 in a bit-1 cell. -> data_o=16'h7BEF; border pixels still F800.

Source files
------------

// File: rtl/video_osd_pkg.sv
// ---------------------------------------------------------------------------
// video_osd_pkg
//  Shared constants for the OSD status overlay: RGB565 colours, the
//  status-bar cell layout and the 50% blend helper used by the alpha build.
//  No ports (package).
// ---------------------------------------------------------------------------
package video_osd_pkg;
    localparam logic [15:0] OSD_WHITE = 16'hFFFF;   // bit = 1
    localparam logic [15:0] OSD_DARK  = 16'h2104;   // bit = 0
    localparam logic [15:0] OSD_BLACK = 16'h0000;   // cell separator
    localparam logic [15:0] OSD_RED   = 16'hF800;   // save border

    localparam int OSD_CELLS       = 12;
    localparam int OSD_STATE_CELLS = 4;
    localparam logic [15:0] RGB565_HALF_MASK = 16'h7BEF;

    // Halve each channel (dropping the bit that would bleed into the next
    // field) and add: a 50/50 mix that can never carry between channels.
    function automatic logic [15:0] rgb565_blend(input logic [15:0] a, input logic [15:0] b);
        return ((a >> 1) & RGB565_HALF_MASK) + ((b >> 1) & RGB565_HALF_MASK);
    endfunction
endpackage

// File: rtl/video_osd_overlay_cell_decoder.sv
// ---------------------------------------------------------------------------
// osd_cell_decoder
//  Combinational map from pixel coordinates to status-bar geometry.
//  Ports:
//   x, y      in   pixel coordinates within the active picture
//   in_box    out  pixel lies inside the 12-cell status bar
//   cell_idx  out  cell number 0..11 (valid when in_box)
//   is_sep    out  pixel is on the last column or last row of its cell
// ---------------------------------------------------------------------------
module osd_cell_decoder
    import video_osd_pkg::*;
#(
    parameter int unsigned XW     = 10,
    parameter int unsigned YW     = 10,
    parameter int unsigned BOX_X  = 16,
    parameter int unsigned BOX_Y  = 16,
    parameter int unsigned CELL_W = 16,
    parameter int unsigned CELL_H = 16
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          in_box,
    output logic [3:0]    cell_idx,
    output logic          is_sep
);
    logic [31:0] xx;
    logic [31:0] yy;
    logic [31:0] col_lo;

    always_comb begin
        xx       = 32'(x);
        yy       = 32'(y);
        in_box   = (xx >= BOX_X) && (xx < BOX_X + OSD_CELLS * CELL_W) &&
                   (yy >= BOX_Y) && (yy < BOX_Y + CELL_H);
        // Compare chain instead of a divider: the last cell start at or
        // below x wins.
        cell_idx = 4'd0;
        col_lo   = 32'(BOX_X);
        for (int c = 1; c < OSD_CELLS; c++) begin
            if (xx >= 32'(BOX_X + c * CELL_W)) begin
                cell_idx = 4'(c);
                col_lo   = 32'(BOX_X + c * CELL_W);
            end
        end
        is_sep = (xx == col_lo + 32'(CELL_W - 1)) || (yy == 32'(BOX_Y + CELL_H - 1));
    end
endmodule

// File: rtl/video_osd_overlay.sv
// ---------------------------------------------------------------------------
// video_osd_overlay
//  Status overlay between the timing generator and the VGA pins. Draws a
//  12-cell bit display (4 cells state_code, 8 cells page_num) and a blinking
//  red frame border while a photo save runs. Fixed 2-cycle latency on every
//  path so syncs stay aligned with the pixels.
//  Build option: define OSD_ALPHA_EN to blend status-bar pixels 50% with
//  the video instead of drawing them opaque (border stays opaque).
//  Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   osd_en                overlay enable (0 = passthrough, same latency)
//   saving                photo save in progress
//   state_code, page_num  fields shown in the bar (latched per frame)
//   hs_i, vs_i, de_i      timing inputs
//   data_i                RGB565 pixel in
//   hs_o, vs_o, de_o      timing delayed 2 cycles
//   data_o                RGB565 pixel out, 2 cycles after data_i
// ---------------------------------------------------------------------------
module video_osd_overlay
    import video_osd_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned BOX_X        = 16,
    parameter int unsigned BOX_Y        = 16,
    parameter int unsigned CELL_W       = 16,
    parameter int unsigned CELL_H       = 16,
    parameter int unsigned BORDER_W     = 4,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter bit          SYNC_POL     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        osd_en,
    input  logic        saving,
    input  logic [3:0]  state_code,
    input  logic [7:0]  page_num,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [15:0] data_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [15:0] data_o
);
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [XW-1:0] X_MAX    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

    // coordinates of the pixel currently at the inputs
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    // per-frame state
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_on_q, phase_on_d;
    logic          save_lat_q, save_lat_d;
    logic [OSD_STATE_CELLS-1:0] state_lat_q, state_lat_d;
    logic [7:0]    page_lat_q, page_lat_d;
    // stage 1
    logic          hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, de_s1_q, de_s1_d;
    logic          en_s1_q, en_s1_d, box_s1_q, box_s1_d;
    logic          sep_s1_q, sep_s1_d, brd_s1_q, brd_s1_d;
    logic [3:0]    cell_s1_q, cell_s1_d;
    logic [15:0]   data_s1_q, data_s1_d;
    // stage 2
    logic          hs_o_q, hs_o_d, vs_o_q, vs_o_d, de_o_q, de_o_d;
    logic [15:0]   data_o_q, data_o_d;

    logic          box_hit, sep_hit, brd_hit;
    logic [3:0]    cell_hit;
    logic          de_fall, frame_start;
    logic [31:0]   xx, yy;
    logic [15:0]   field_bits, osd_pix, box_pix;
    logic [3:0]    bit_idx;

    osd_cell_decoder #(
        .XW(XW), .YW(YW), .BOX_X(BOX_X), .BOX_Y(BOX_Y), .CELL_W(CELL_W), .CELL_H(CELL_H)
    ) u_dec (
        .x(x_q), .y(y_q), .in_box(box_hit), .cell_idx(cell_hit), .is_sep(sep_hit)
    );

    // Stage-1 copies of de/vs double as the previous-cycle values for edge
    // detection.
    assign de_fall     = de_s1_q & ~de_i;
    assign frame_start = (vs_i == SYNC_POL) && (vs_s1_q != SYNC_POL);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        save_lat_d  = save_lat_q;
        state_lat_d = state_lat_q;
        page_lat_d  = page_lat_q;

        if (!de_i)             x_d = '0;
        else if (x_q != X_MAX) x_d = x_q + 1'b1;

        if (frame_start)                     y_d = '0;
        else if (de_fall && (y_q != Y_MAX))  y_d = y_q + 1'b1;

        if (frame_start) begin
            save_lat_d  = saving;
            state_lat_d = state_code;
            page_lat_d  = page_num;
            // The counter only runs across consecutive saving frames, so a
            // new save always opens with a full lit phase.
            if (saving && save_lat_q) begin
                if (blink_cnt_q == CNT_LAST) begin
                    blink_cnt_d = '0;
                    phase_on_d  = ~phase_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end else begin
                blink_cnt_d = '0;
                phase_on_d  = 1'b1;
            end
        end
    end

    always_comb begin
        xx        = 32'(x_q);
        yy        = 32'(y_q);
        brd_hit   = (xx < BORDER_W) || (xx >= H_ACTIVE - BORDER_W) ||
                    (yy < BORDER_W) || (yy >= V_ACTIVE - BORDER_W);
        hs_s1_d   = hs_i;
        vs_s1_d   = vs_i;
        de_s1_d   = de_i;
        data_s1_d = data_i;
        en_s1_d   = osd_en;
        box_s1_d  = box_hit;
        cell_s1_d = cell_hit;
        sep_s1_d  = sep_hit;
        brd_s1_d  = brd_hit;
    end

    always_comb begin
        // cell 0 shows the MSB of state_code, cell 11 the LSB of page_num
        field_bits = {4'b0000, state_lat_q, page_lat_q};
        bit_idx    = 4'(OSD_CELLS - 1) - cell_s1_q;
        osd_pix    = sep_s1_q ? OSD_BLACK : (field_bits[bit_idx] ? OSD_WHITE : OSD_DARK);
`ifdef OSD_ALPHA_EN
        box_pix    = rgb565_blend(data_s1_q, osd_pix);
`else
        box_pix    = osd_pix;
`endif
        hs_o_d     = hs_s1_q;
        vs_o_d     = vs_s1_q;
        de_o_d     = de_s1_q;
        data_o_d   = data_s1_q;
        if (de_s1_q && en_s1_q) begin
            if (box_s1_q)                                   data_o_d = box_pix;
            else if (brd_s1_q && save_lat_q && phase_on_q)  data_o_d = OSD_RED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            save_lat_q  <= 1'b0;
            state_lat_q <= '0;
            page_lat_q  <= '0;
            hs_s1_q     <= ~SYNC_POL;
            vs_s1_q     <= ~SYNC_POL;
            de_s1_q     <= 1'b0;
            data_s1_q   <= '0;
            en_s1_q     <= 1'b0;
            box_s1_q    <= 1'b0;
            cell_s1_q   <= '0;
            sep_s1_q    <= 1'b0;
            brd_s1_q    <= 1'b0;
            hs_o_q      <= ~SYNC_POL;
            vs_o_q      <= ~SYNC_POL;
            de_o_q      <= 1'b0;
            data_o_q    <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            save_lat_q  <= save_lat_d;
            state_lat_q <= state_lat_d;
            page_lat_q  <= page_lat_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            de_s1_q     <= de_s1_d;
            data_s1_q   <= data_s1_d;
            en_s1_q     <= en_s1_d;
            box_s1_q    <= box_s1_d;
            cell_s1_q   <= cell_s1_d;
            sep_s1_q    <= sep_s1_d;
            brd_s1_q    <= brd_s1_d;
            hs_o_q      <= hs_o_d;
            vs_o_q      <= vs_o_d;
            de_o_q      <= de_o_d;
            data_o_q    <= data_o_d;
        end
    end

    assign hs_o   = hs_o_q;
    assign vs_o   = vs_o_q;
    assign de_o   = de_o_q;
    assign data_o = data_o_q;
endmodule

// File: tb/tb_video_osd_overlay.sv
// ---------------------------------------------------------------------------
// tb_video_osd_overlay
//  Drives a small raster (224x34 active, active-low syncs, 2-frame blink)
//  through the overlay. Each driven cycle pushes the expected output into a
//  scoreboard queue; a monitor pops and compares two cycles later.
// ---------------------------------------------------------------------------
module tb_video_osd_overlay;
    localparam int H  = 224;
    localparam int V  = 34;
    localparam int HB = 8;
    localparam int VB = 2;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst, osd_en, saving, hs_i, vs_i, de_i;
    logic [3:0]  state_code;
    logic [7:0]  page_num;
    logic [15:0] data_i;
    logic        hs_o, vs_o, de_o;
    logic [15:0] data_o;

    video_osd_overlay #(.H_ACTIVE(H), .V_ACTIVE(V), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .osd_en(osd_en), .saving(saving),
        .state_code(state_code), .page_num(page_num),
        .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] v;     // {hs, vs, de, data}
        int          kind;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // values applied to the DUT inputs on the next driven cycle
    logic        nx_saving;
    logic [3:0]  nx_state;
    logic [7:0]  nx_page;
    logic [15:0] ramp = 16'h0000;

    // reference state: what a viewer of each frame should see
    logic [3:0]  m_state = 4'h0;
    logic [7:0]  m_page = 8'h00;
    bit          m_save = 1'b0;
    int          m_run = 0;     // index of this frame within a run of saving frames
    logic        prev_vs = 1'b1;

    function automatic string kname(input int k);
        case (k)
            1: return "cell";
            2: return "sep";
            3: return "border";
            default: return "pass";
        endcase
    endfunction

    task automatic model_pix(input int x, input int y, input logic [15:0] d, input logic en,
                             output logic [15:0] p, output int k);
        logic [11:0] bits;
        logic [15:0] o;
        int c;
        p = d;
        k = 0;
        if (!en) return;
        if (x >= 16 && x < 16 + 12 * 16 && y >= 16 && y < 32) begin
            c    = (x - 16) / 16;
            bits = {m_state, m_page};
            if (((x - 16) % 16) == 15 || ((y - 16) % 16) == 15) begin
                o = 16'h0000;
                k = 2;
            end else begin
                o = bits[11 - c] ? 16'hFFFF : 16'h2104;
                k = 1;
            end
`ifdef OSD_ALPHA_EN
            p = ((d >> 1) & 16'h7BEF) + ((o >> 1) & 16'h7BEF);
`else
            p = o;
`endif
        end else if (m_save && ((m_run / BF) % 2 == 0) &&
                     (x < 4 || x >= H - 4 || y < 4 || y >= V - 4)) begin
            p = 16'hF800;
            k = 3;
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic de, input logic [15:0] d,
                         input logic en, input int x, input int y);
        exp_t e;
        logic [15:0] p;
        int k;
        @(negedge clk);
        rst        = 1'b0;
        hs_i       = hs;
        vs_i       = vs;
        de_i       = de;
        data_i     = d;
        osd_en     = en;
        saving     = nx_saving;
        state_code = nx_state;
        page_num   = nx_page;
        if (vs == 1'b0 && prev_vs == 1'b1) begin
            if (saving && m_save) m_run++;
            else                  m_run = 0;
            m_save  = saving;
            m_state = state_code;
            m_page  = page_num;
        end
        prev_vs = vs;
        if (de) model_pix(x, y, d, en, p, k);
        else begin
            p = d;
            k = 0;
        end
        e.v    = {hs, vs, de, p};
        e.kind = k;
        e.due  = cyc + 2;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] pix_data(input int fi);
        if (fi == 3) begin
            ramp = ramp + 16'd1;
            return ramp;
        end
        return 16'($urandom);
    endfunction

    function automatic logic pix_en(input int fi);
        if (fi == 3) return 1'b0;
        if (fi == 4) return ($urandom_range(0, 7) != 0);
        return 1'b1;
    endfunction

    task automatic run_frame(input int fi);
        logic vsv;
        int   al, len, nb;
        for (int ln = 0; ln < VB + V; ln++) begin
            vsv = (ln == 0) ? 1'b0 : 1'b1;
            al  = ln - VB;
            if (fi == 1 && al == 10) nx_page = 8'h06;      // must not show until next frame
            if (fi == 5 && al == 5)  nx_saving = 1'b0;     // border persists this frame
            if (ln >= VB) begin
                len = (fi == 6 && al == 20) ? 1100 : H;    // long de: x must saturate
                for (int p = 0; p < len; p++)
                    drive(1'b1, vsv, 1'b1, pix_data(fi), pix_en(fi), (p < H) ? p : H - 1, al);
            end
            nb = (ln < VB) ? H + HB : HB;
            for (int b = 0; b < nb; b++)
                drive((b >= 2 && b < 6) ? 1'b0 : 1'b1, vsv, 1'b0, pix_data(fi), pix_en(fi), 0, 0);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    // monitor: compare each output against the entry due on this cycle
    initial begin
        exp_t e;
        logic [18:0] got;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e   = sb.pop_front();
                got = {hs_o, vs_o, de_o, data_o};
                n_checks++;
                if (e.due == cyc && got == e.v) n_pass++;
                else $display("FAIL %s cyc=%0d got=%h expected=%h", kname(e.kind), cyc, got, e.v);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; osd_en = 1'b1; saving = 1'b1; state_code = 4'hF; page_num = 8'hFF;
        hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b1; data_i = 16'hABCD;
        nx_saving = 1'b1; nx_state = 4'b1010; nx_page = 8'h05;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hs", 32'(hs_o), 32'd1);
        chk("reset_vs", 32'(vs_o), 32'd1);
        chk("reset_de", 32'(de_o), 32'd0);
        chk("reset_data", 32'(data_o), 32'd0);
        hs_i = 1'b1; vs_i = 1'b1; de_i = 1'b0;

        for (int fi = 0; fi < 8; fi++) begin
            if (fi == 4 || fi == 7) begin
                nx_state = 4'($urandom);
                nx_page  = 8'($urandom);
            end
            if (fi == 7) nx_saving = 1'b1;
            run_frame(fi);
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
